mpu_load_stream: RTL and testbench

MPU_LOAD_STREAM -- requirements
Module: mpu_load_stream

---
 rtl/mpu_load_stream_if.sv | 21 ++
 rtl/mpu_load_stream.sv | 200 ++++++++++++++++++++
 tb/tb_mpu_load_stream.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mpu_load_stream_if.sv
// rtl/mpu_load_stream_if.sv - element beat stream from memory into the matrix loader
interface mpu_load_stream_if #(
    parameter int LANES = 2,
    parameter int FW    = 32
) ();
    logic                  mem_valid_in;
    logic                  mem_ready_out;
    logic [LANES*FW-1:0]   mem_load_element_in;

    modport master (
        output mem_valid_in,
        output mem_load_element_in,
        input  mem_ready_out
    );

    modport slave (
        input  mem_valid_in,
        input  mem_load_element_in,
        output mem_ready_out
    );
endinterface

// File: rtl/mpu_load_stream.sv
// rtl/mpu_load_stream.sv - streams matrix elements into a register file, MPU_LOAD_TRANSPOSE_EN adds column-major
// Lane k of each beat lands at (i, j+k) row-major or (i+k, j) column-major; writes are registered.
module mpu_load_stream #(
    parameter int M_MAX = 4,
    parameter int N_MAX = 4,
    parameter int FW    = 32,
    parameter int LANES = 2,
    parameter int AW    = 3,
    localparam int MW   = $clog2(M_MAX + 1),
    localparam int NW   = $clog2(N_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_req_in,
    input  logic [MW-1:0]       mem_m_load_size_in,
    input  logic [NW-1:0]       mem_n_load_size_in,
    input  logic [AW-1:0]       mem_load_addr_in,
    input  logic                mem_transpose_in,
    mpu_load_stream_if.slave    mem,
    output logic                mem_load_error_out,
    output logic                mem_load_done_out,
    output logic                busy_out,
    input  logic                load_ready_in,
    output logic [LANES-1:0]    reg_load_en_out,
    output logic [LANES*FW-1:0] reg_load_element_out,
    output logic [AW-1:0]       reg_load_addr_out,
    output logic [MW-1:0]       reg_i_load_loc_out,
    output logic [NW-1:0]       reg_j_load_loc_out,
    output logic [MW-1:0]       reg_m_load_size_out,
    output logic [NW-1:0]       reg_n_load_size_out
);

    typedef enum logic [1:0] {IDLE, REQUEST, LOAD, DONE} state_t;

    state_t              state_q, state_d;
    logic [MW-1:0]       m_q, m_d;
    logic [NW-1:0]       n_q, n_d;
    logic [MW-1:0]       i_q, i_d;
    logic [NW-1:0]       j_q, j_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic                transpose_q, transpose_d;
    logic                error_q, error_d;
    logic [LANES-1:0]    en_q, en_d;
    logic [LANES*FW-1:0] data_q, data_d;
    logic [MW-1:0]       loc_i_q, loc_i_d;
    logic [NW-1:0]       loc_j_q, loc_j_d;

    logic                transpose_req;
    logic                size_err;
    logic                accept;
    logic [LANES-1:0]    lane_en;
    logic                row_wrap;
    logic                col_wrap;
    logic                last_beat;

`ifdef MPU_LOAD_TRANSPOSE_EN
    assign transpose_req = mem_transpose_in;
`else
    logic unused_transpose;
    assign unused_transpose = mem_transpose_in;
    assign transpose_req    = 1'b0;
`endif

    assign size_err = (mem_m_load_size_in == '0) || (mem_n_load_size_in == '0) ||
                      (int'(mem_m_load_size_in) > M_MAX) || (int'(mem_n_load_size_in) > N_MAX);

    assign mem.mem_ready_out = (state_q == LOAD) && load_ready_in;
    assign accept            = mem.mem_ready_out && mem.mem_valid_in;

    // Lanes past the matrix edge are masked; the wrap flags decide pointer advance and the final beat.
    always_comb begin
        lane_en = '0;
        for (int k = 0; k < LANES; k++) begin
            if (transpose_q) begin
                lane_en[k] = (int'(i_q) + k) < int'(m_q);
            end else begin
                lane_en[k] = (int'(j_q) + k) < int'(n_q);
            end
        end
        row_wrap  = (int'(j_q) + LANES) >= int'(n_q);
        col_wrap  = (int'(i_q) + LANES) >= int'(m_q);
        last_beat = transpose_q ? (col_wrap && (int'(j_q) == int'(n_q) - 1))
                                : (row_wrap && (int'(i_q) == int'(m_q) - 1));
    end

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        i_d         = i_q;
        j_d         = j_q;
        addr_d      = addr_q;
        transpose_d = transpose_q;
        error_d     = error_q;
        en_d        = '0;
        data_d      = data_q;
        loc_i_d     = loc_i_q;
        loc_j_d     = loc_j_q;

        case (state_q)
            IDLE: begin
                if (load_req_in) begin
                    if (size_err) begin
                        error_d = 1'b1;
                    end else begin
                        m_d         = mem_m_load_size_in;
                        n_d         = mem_n_load_size_in;
                        addr_d      = mem_load_addr_in;
                        transpose_d = transpose_req;
                        error_d     = 1'b0;
                        i_d         = '0;
                        j_d         = '0;
                        state_d     = REQUEST;
                    end
                end
            end
            REQUEST: begin
                if (load_ready_in) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    en_d    = lane_en;
                    data_d  = mem.mem_load_element_in;
                    loc_i_d = i_q;
                    loc_j_d = j_q;
                    if (transpose_q) begin
                        if (col_wrap) begin
                            i_d = '0;
                            j_d = j_q + NW'(1);
                        end else begin
                            i_d = i_q + MW'(LANES);
                        end
                    end else begin
                        if (row_wrap) begin
                            j_d = '0;
                            i_d = i_q + MW'(1);
                        end else begin
                            j_d = j_q + NW'(LANES);
                        end
                    end
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_q         <= '0;
            n_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            addr_q      <= '0;
            transpose_q <= 1'b0;
            error_q     <= 1'b0;
            en_q        <= '0;
            data_q      <= '0;
            loc_i_q     <= '0;
            loc_j_q     <= '0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            i_q         <= i_d;
            j_q         <= j_d;
            addr_q      <= addr_d;
            transpose_q <= transpose_d;
            error_q     <= error_d;
            en_q        <= en_d;
            data_q      <= data_d;
            loc_i_q     <= loc_i_d;
            loc_j_q     <= loc_j_d;
        end
    end

    assign mem_load_error_out   = error_q;
    assign mem_load_done_out    = (state_q == DONE);
    assign busy_out             = (state_q != IDLE);
    assign reg_load_en_out      = en_q;
    assign reg_load_element_out = data_q;
    assign reg_load_addr_out    = addr_q;
    assign reg_i_load_loc_out   = loc_i_q;
    assign reg_j_load_loc_out   = loc_j_q;
    assign reg_m_load_size_out  = m_q;
    assign reg_n_load_size_out  = n_q;

endmodule

// File: tb/tb_mpu_load_stream.sv
// tb/tb_mpu_load_stream.sv - self-checking bench for mpu_load_stream
module tb_mpu_load_stream;
    localparam int M_MAX = 4;
    localparam int N_MAX = 4;
    localparam int FW    = 32;
    localparam int LANES = 2;
    localparam int AW    = 3;
    localparam int MW    = 3;
    localparam int NW    = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                load_req_in;
    logic [MW-1:0]       req_m;
    logic [NW-1:0]       req_n;
    logic [AW-1:0]       req_addr;
    logic                req_tr;
    logic                load_ready_in;
    logic                err_out, done_out, busy_out;
    logic [LANES-1:0]    en_out;
    logic [LANES*FW-1:0] data_out;
    logic [AW-1:0]       addr_out;
    logic [MW-1:0]       i_out, m_out;
    logic [NW-1:0]       j_out, n_out;

    always #5 clk = ~clk;

    mpu_load_stream_if #(.LANES(LANES), .FW(FW)) mem_if ();

    mpu_load_stream #(.M_MAX(M_MAX), .N_MAX(N_MAX), .FW(FW), .LANES(LANES), .AW(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .load_req_in          (load_req_in),
        .mem_m_load_size_in   (req_m),
        .mem_n_load_size_in   (req_n),
        .mem_load_addr_in     (req_addr),
        .mem_transpose_in     (req_tr),
        .mem                  (mem_if),
        .mem_load_error_out   (err_out),
        .mem_load_done_out    (done_out),
        .busy_out             (busy_out),
        .load_ready_in        (load_ready_in),
        .reg_load_en_out      (en_out),
        .reg_load_element_out (data_out),
        .reg_load_addr_out    (addr_out),
        .reg_i_load_loc_out   (i_out),
        .reg_j_load_loc_out   (j_out),
        .reg_m_load_size_out  (m_out),
        .reg_n_load_size_out  (n_out)
    );

    typedef struct {
        int               i;
        int               j;
        logic [LANES-1:0] mask;
        bit               last;
    } beat_t;

    typedef struct {
        int m;
        int n;
        bit tr;
        int addr;
        bit err;
    } vec_t;

    beat_t               exp_q[$];
    beat_t               pend_beat;
    logic [LANES*FW-1:0] pend_data;
    bit                  pend = 0;
    int                  cur_m = 0, cur_n = 0, cur_addr = 0;
    int                  n_tests = 0, n_fail = 0;
    vec_t                vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the matrix in stream order, chunking each row (or column) into LANES-wide beats.
    function automatic void build(input int m, input int n, input bit tr);
        beat_t b;
        bit    col;
`ifdef MPU_LOAD_TRANSPOSE_EN
        col = tr;
`else
        col = 1'b0;
        if (tr) col = 1'b0;
`endif
        exp_q.delete();
        if (col) begin
            for (int j = 0; j < n; j++)
                for (int i = 0; i < m; i += LANES) begin
                    b.i = i; b.j = j; b.last = 1'b0;
                    for (int k = 0; k < LANES; k++) b.mask[k] = (i + k < m);
                    exp_q.push_back(b);
                end
        end else begin
            for (int i = 0; i < m; i++)
                for (int j = 0; j < n; j += LANES) begin
                    b.i = i; b.j = j; b.last = 1'b0;
                    for (int k = 0; k < LANES; k++) b.mask[k] = (j + k < n);
                    exp_q.push_back(b);
                end
        end
        exp_q[exp_q.size() - 1].last = 1'b1;
    endfunction

    task automatic cycle(input bit valid, input bit lready, input bit req);
        @(negedge clk);
        if (pend) begin
            check("wr_en", en_out, pend_beat.mask);
            check("wr_i", i_out, pend_beat.i);
            check("wr_j", j_out, pend_beat.j);
            check("wr_data", data_out, pend_data);
            check("wr_addr", addr_out, cur_addr);
            check("wr_done", done_out, pend_beat.last);
        end else begin
            check("nowr_en", en_out, 0);
            check("nowr_done", done_out, 0);
        end
        mem_if.mem_valid_in        = valid;
        mem_if.mem_load_element_in = {$urandom, $urandom};
        load_ready_in              = lready;
        load_req_in                = req;
        #1;
        pend = 1'b0;
        if (valid && mem_if.mem_ready_out) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_beat: beat accepted after final element");
            end else begin
                pend_beat = exp_q.pop_front();
                pend_data = mem_if.mem_load_element_in;
                pend      = 1'b1;
            end
        end
    endtask

    task automatic request(input int m, input int n, input bit tr, input int addr, input bit lready, input bit exp_err);
        req_m    = MW'(m);
        req_n    = NW'(n);
        req_tr   = tr;
        req_addr = AW'(addr);
        cycle(1'b0, lready, 1'b1);
        @(posedge clk);
        #1;
        check("error", err_out, exp_err);
        check("busy", busy_out, !exp_err);
        if (!exp_err) begin
            cur_m = m; cur_n = n; cur_addr = addr;
            build(m, n, tr);
        end
        check("m_size", m_out, cur_m);
        check("n_size", n_out, cur_n);
    endtask

    task automatic finish_load(input bit rnd);
        int budget = 0;
        while ((exp_q.size() > 0 || pend) && budget < 500) begin
            bit v, lr, rq;
            v  = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            lr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rq = rnd && ($urandom_range(0, 7) == 0) && (exp_q.size() > 0);
            if (rq) begin
                req_m = MW'($urandom);
                req_n = NW'($urandom);
            end
            if (exp_q.size() == 0) v = 1'b0;
            cycle(v, lr, rq);
            budget++;
        end
        if (budget >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL load_timeout: %0d beats outstanding", exp_q.size());
        end
        @(posedge clk);
        #1;
        check("end_busy", busy_out, 0);
        check("end_done", done_out, 0);
        check("end_error", err_out, 0);
        check("end_m_size", m_out, cur_m);
        check("end_n_size", n_out, cur_n);
    endtask

    initial begin
        rst_n = 1'b0;
        load_req_in = 1'b0; load_ready_in = 1'b0;
        req_m = '0; req_n = '0; req_addr = '0; req_tr = 1'b0;
        mem_if.mem_valid_in = 1'b0;
        mem_if.mem_load_element_in = '0;
        #12;
        check("rst_busy", busy_out, 0);
        check("rst_ready", mem_if.mem_ready_out, 0);
        check("rst_en", en_out, 0);
        check("rst_done", done_out, 0);
        check("rst_error", err_out, 0);
        check("rst_m", m_out, 0);
        check("rst_n_size", n_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{3, 3, 1'b0, 1, 1'b0};
        vecs[1] = '{0, 2, 1'b0, 2, 1'b1};
        vecs[2] = '{2, 5, 1'b0, 2, 1'b1};
        vecs[3] = '{4, 4, 1'b0, 7, 1'b0};
        vecs[4] = '{5, 1, 1'b0, 0, 1'b1};
        vecs[5] = '{3, 2, 1'b1, 4, 1'b0};
        vecs[6] = '{1, 1, 1'b0, 1, 1'b0};
        vecs[7] = '{4, 1, 1'b1, 2, 1'b0};
        vecs[8] = '{2, 4, 1'b1, 3, 1'b0};
        vecs[9] = '{4, 3, 1'b0, 6, 1'b0};
        for (int t = 0; t < 10; t++) begin
            request(vecs[t].m, vecs[t].n, vecs[t].tr, vecs[t].addr, 1'($urandom_range(0, 1)), vecs[t].err);
            if (!vecs[t].err) finish_load(1'b1);
        end

        // 4x4 with load_ready_in dropped for three cycles mid-load
        request(4, 4, 1'b0, 5, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check("stall_ready", mem_if.mem_ready_out, 0);
        end
        finish_load(1'b0);

        // asynchronous reset in the middle of a 4x4, then a clean 2x2
        request(4, 4, 1'b1, 3, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", en_out, 0);
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_ready", mem_if.mem_ready_out, 0);
        check("mid_rst_done", done_out, 0);
        check("mid_rst_m", m_out, 0);
        check("mid_rst_i", i_out, 0);
        check("mid_rst_data", data_out, 0);
        pend = 1'b0;
        exp_q.delete();
        cur_m = 0; cur_n = 0; cur_addr = 0;
        mem_if.mem_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        request(2, 2, 1'b0, 6, 1'b1, 1'b0);
        finish_load(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
